// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file, x0 hardwired to zero, same-cycle write bypass,
// sequential post-reset clear engine. Busy scoreboard ports exist only when REGFILE_SCOREBOARD_EN is defined.
module regfile_mp #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned NRD   = 2,
   parameter int unsigned NWR   = 1,
   localparam int unsigned AW   = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                reset,
   output logic                ready,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data
`ifdef REGFILE_SCOREBOARD_EN
   ,
   input  logic                rsv_en,
   input  logic [AW-1:0]       rsv_addr,
   output logic [NRD-1:0]      rd_busy
`endif
);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   clr_idx, clr_idx_nxt;
   logic            ready_nxt;
   logic            clr_we;
   logic [NWR-1:0]  wr_commit;
   logic [XLEN-1:0] regs [NREGS];

   // State register; reset restarts the clear sequence from entry 0
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_CLEAR;
         clr_idx <= '0;
         ready   <= 1'b0;
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
         ready   <= ready_nxt;
      end
   end

   // Next state: walk the array once, then run
   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      ready_nxt   = ready;
      clr_we      = 1'b0;
      case (state)
         ST_CLEAR: begin
            clr_we      = 1'b1;
            clr_idx_nxt = clr_idx + AW'(1);
            if (clr_idx == AW'(NREGS - 1)) begin
               state_nxt = ST_RUN;
               ready_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      wr_commit = '0;
      for (int unsigned w = 0; w < NWR; w++) begin
         wr_commit[w] = (state == ST_RUN) && wr_en[w] && (wr_addr[w*AW +: AW] != '0);
      end
   end

   // Array update; later ports override earlier ones on the same index
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (clr_we) begin
            regs[clr_idx] <= '0;
         end
         for (int unsigned w = 0; w < NWR; w++) begin
            if (wr_commit[w]) begin
               regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
            end
         end
      end
   end

   // Read ports with bypass from the highest matching write port
   always_comb begin
      rd_data = '0;
      for (int unsigned p = 0; p < NRD; p++) begin
         if ((state == ST_RUN) && (rd_addr[p*AW +: AW] != '0)) begin
            rd_data[p*XLEN +: XLEN] = regs[rd_addr[p*AW +: AW]];
            for (int unsigned w = 0; w < NWR; w++) begin
               if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW])) begin
                  rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
               end
            end
         end
      end
   end

`ifdef REGFILE_SCOREBOARD_EN
   logic [NREGS-1:0] busy;

   // Committed writes release a register; a same-cycle reservation wins
   always_ff @(posedge clk) begin
      if (reset || (state == ST_CLEAR)) begin
         busy <= '0;
      end else begin
         for (int unsigned w = 0; w < NWR; w++) begin
            if (wr_commit[w]) begin
               busy[wr_addr[w*AW +: AW]] <= 1'b0;
            end
         end
         if (rsv_en && (rsv_addr != '0)) begin
            busy[rsv_addr] <= 1'b1;
         end
      end
   end

   always_comb begin
      rd_busy = '0;
      for (int unsigned p = 0; p < NRD; p++) begin
         rd_busy[p] = busy[rd_addr[p*AW +: AW]];
      end
   end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp (2 read, 2 write ports); covers the busy
// scoreboard too when REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_mp;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned NRD   = 2;
   localparam int unsigned NWR   = 2;
   localparam int unsigned AW    = 5;

   logic                clk = 1'b0;
   logic                reset;
   logic                ready;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
`ifdef REGFILE_SCOREBOARD_EN
   logic                rsv_en;
   logic [AW-1:0]       rsv_addr;
   logic [NRD-1:0]      rd_busy;
`endif

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
      .clk     (clk),
      .reset   (reset),
      .ready   (ready),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
`ifdef REGFILE_SCOREBOARD_EN
      ,
      .rsv_en  (rsv_en),
      .rsv_addr(rsv_addr),
      .rd_busy (rd_busy)
`endif
   );

   typedef struct {
      logic [NRD*XLEN-1:0] rd;
      logic                rdy;
      logic [NRD-1:0]      bsy;
   } exp_t;

   exp_t             exp_q[$];
   int               n_checks = 0;
   int               n_err    = 0;
   logic [XLEN-1:0]  mdl [NREGS];
   bit               mdl_run  = 1'b0;
   int               mdl_idx  = 0;
   logic [NREGS-1:0] mdl_busy = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference read: x0 and the clear phase read zero, port 1 beats port 0 on a bypass
   function automatic logic [XLEN-1:0] mdl_read(input logic [AW-1:0] a);
      if (!mdl_run || a == '0) return '0;
      if (wr_en[1] && wr_addr[9:5] == a) return wr_data[63:32];
      if (wr_en[0] && wr_addr[4:0] == a) return wr_data[31:0];
      return mdl[a];
   endfunction

   task automatic model_edge();
      if (reset) begin
         mdl_run  = 1'b0;
         mdl_idx  = 0;
         mdl_busy = '0;
      end else if (!mdl_run) begin
         mdl[mdl_idx] = '0;
         if (mdl_idx == NREGS - 1) mdl_run = 1'b1;
         mdl_idx++;
      end else begin
         if (wr_en[0] && wr_addr[4:0] != '0) begin
            mdl[wr_addr[4:0]]      = wr_data[31:0];
            mdl_busy[wr_addr[4:0]] = 1'b0;
         end
         if (wr_en[1] && wr_addr[9:5] != '0) begin
            mdl[wr_addr[9:5]]      = wr_data[63:32];
            mdl_busy[wr_addr[9:5]] = 1'b0;
         end
`ifdef REGFILE_SCOREBOARD_EN
         if (rsv_en && rsv_addr != '0) mdl_busy[rsv_addr] = 1'b1;
`endif
      end
   endtask

   // One clock: push the expectation for the driven inputs, compare at negedge, advance the model
   task automatic cycle(input string tag);
      exp_t e;
      e.rd  = {mdl_read(rd_addr[9:5]), mdl_read(rd_addr[4:0])};
      e.rdy = mdl_run;
      e.bsy = {mdl_busy[rd_addr[9:5]], mdl_busy[rd_addr[4:0]]};
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      check({tag, "_rd"}, 64'(rd_data), 64'(e.rd));
      check({tag, "_rdy"}, 64'(ready), 64'(e.rdy));
`ifdef REGFILE_SCOREBOARD_EN
      check({tag, "_bsy"}, 64'(rd_busy), 64'(e.bsy));
`endif
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Count edges until ready rises; optionally pulse a write during the clear
   task automatic run_to_ready(input string tag, input bit pulse);
      int cnt = 0;
      while (ready !== 1'b1 && cnt < 100) begin
         rd_addr = {5'(31 - cnt), 5'(cnt)};
         wr_en   = (pulse && cnt == 5) ? 2'b01 : 2'b00;
         wr_addr = {5'd0, 5'd3};
         wr_data = {32'd0, 32'hAAAA5555};
         cycle(tag);
         cnt++;
      end
      wr_en = '0;
      check({tag, "_len"}, 64'(cnt), 64'd32);
   endtask

   initial begin
      reset   = 1'b1;
      wr_en   = '0;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
`ifdef REGFILE_SCOREBOARD_EN
      rsv_en   = 1'b0;
      rsv_addr = '0;
`endif
      for (int i = 0; i < NREGS; i++) mdl[i] = '0;
      repeat (2) @(posedge clk);
      #1;

      repeat (2) cycle("rst0");
      reset = 1'b0;
      run_to_ready("clr0", 1'b0);

      // Preload every register, then reset with contents in place
      for (int i = 1; i < NREGS; i++) begin
         wr_en   = 2'b01;
         wr_addr = {5'd0, 5'(i)};
         wr_data = {32'd0, 32'(i) * 32'h01010101 ^ 32'hC0DE0000};
         rd_addr = {5'(i - 1), 5'(i)};
         cycle("pre");
      end
      wr_en = '0;
      reset = 1'b1;
      repeat (3) cycle("rst1");
      reset = 1'b0;
      run_to_ready("clr1", 1'b1);
      for (int i = 0; i < NREGS; i++) begin
         rd_addr = {5'(i), 5'(i)};
         #1 check("clr_rd", 64'(rd_data), 64'd0);
         cycle("clr_rd");
      end

      // x0 stays zero under a write
      wr_en = 2'b01; wr_addr = '0; wr_data = {32'd0, 32'hDEADBEEF}; rd_addr = '0;
      #1 check("x0_same", 64'(rd_data[31:0]), 64'd0);
      cycle("x0");
      wr_en = '0;
      #1 check("x0_next", 64'(rd_data[31:0]), 64'd0);
      cycle("x0n");

      // Bypass then committed value
      wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'h12345678}; rd_addr = {5'd0, 5'd5};
      #1 check("byp_same", 64'(rd_data[31:0]), 64'h12345678);
      cycle("byp");
      wr_en = '0;
      #1 check("byp_next", 64'(rd_data[31:0]), 64'h12345678);
      cycle("bypn");

      // Both ports to x7: port 1 wins for bypass and storage
      wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h2, 32'h1}; rd_addr = {5'd7, 5'd7};
      #1 check("conf_same", 64'(rd_data), {32'h2, 32'h2});
      cycle("conf");
      wr_en = '0;
      #1 check("conf_next", 64'(rd_data), {32'h2, 32'h2});
      cycle("confn");

      // Random traffic, reads often aimed at the write targets
      for (int i = 0; i < 300; i++) begin
         wr_en   = 2'($urandom);
         wr_addr = 10'($urandom);
         wr_data = {$urandom, $urandom};
         rd_addr = ($urandom_range(0, 1) == 0) ? {wr_addr[4:0], wr_addr[9:5]} : 10'($urandom);
`ifdef REGFILE_SCOREBOARD_EN
         rsv_en   = 1'($urandom);
         rsv_addr = 5'($urandom);
`endif
         cycle("rnd");
      end
      wr_en = '0;
`ifdef REGFILE_SCOREBOARD_EN
      rsv_en = 1'b0;
`endif

      // Reset again on the 10th clear edge
      reset = 1'b1;
      cycle("rst2");
      reset = 1'b0;
      repeat (9) cycle("mid");
      check("mid_rdy", 64'(ready), 64'd0);
      reset = 1'b1;
      cycle("rst3");
      reset = 1'b0;
      run_to_ready("clr2", 1'b0);

`ifdef REGFILE_SCOREBOARD_EN
      rsv_en = 1'b1; rsv_addr = 5'd9; rd_addr = {5'd0, 5'd9};
      cycle("rsv");
      rsv_en = 1'b0;
      #1 check("busy_set", 64'(rd_busy), 64'b01);
      cycle("rsvn");
      wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'd0, 32'h99}; rsv_en = 1'b1;
      cycle("rsvwr");
      wr_en = '0; rsv_en = 1'b0;
      #1 check("busy_keep", 64'(rd_busy), 64'b01);
      cycle("keepn");
      wr_en = 2'b01;
      cycle("wr9");
      wr_en = '0;
      #1 check("busy_clr", 64'(rd_busy), 64'b00);
      cycle("clrn");
      rsv_en = 1'b1; rsv_addr = '0; rd_addr = '0;
      cycle("rsv0");
      rsv_en = 1'b0;
      #1 check("busy_x0", 64'(rd_busy), 64'b00);
      cycle("rsv0n");
`endif

      check("q_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
